ir_pipeline_ctrl: RTL

Owns the four instruction pipeline registers (IR1 fetch, IR2 register read, IR3 execute, IR4 writeback) and is the writer side of the stage-controller interface: it produces the IR1Out–IR4Out, branching and RFWrite signals that the stage controller decodes for forwarding and FlagWrite. It advances instructions every cycle, resolves branches in IR3, flushes wrong-path instructions to NOPs, drives PC update and writeback control, and halts the machine on stop.

---
 rtl/ir_pipeline_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ir_pipeline_ctrl.sv
// Four-stage instruction register pipeline with branch flush, stop/halt sequencing and writeback control.
// Optional retire/flush statistics counters are enabled by defining IR_PIPE_STATS_EN.
module ir_pipeline_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  InstrIn,
  input  logic        N,
  input  logic        Z,
  output logic [7:0]  IR1Out,
  output logic [7:0]  IR2Out,
  output logic [7:0]  IR3Out,
  output logic [7:0]  IR4Out,
  output logic        branching,
  output logic        PCSel,
  output logic        PCWrite,
  output logic        RFWrite,
  output logic [1:0]  RegWSel,
  output logic        MemWrite,
  output logic        Halted
`ifdef IR_PIPE_STATS_EN
  ,
  output logic [15:0] RetireCount,
  output logic [15:0] FlushCount
`endif
);

  localparam logic [7:0] NOP = 8'h0A;

  typedef enum logic [1:0] {RUN, FREEZE, DRAIN, HALT} state_t;
  typedef enum logic [3:0] {
    K_NOP, K_LOAD, K_STOP, K_STORE, K_ALU, K_SHIFT, K_ORI, K_BZ, K_BNZ, K_BPZ
  } kind_t;

  state_t state;
  kind_t  kind2, kind3, kind4;
  logic   taken;

  function automatic kind_t decode(input logic [7:0] ir);
    kind_t k;
    k = K_NOP;
    if (ir[3:0] == 4'b0100 || ir[3:0] == 4'b0110 || ir[3:0] == 4'b1000) k = K_ALU;
    else if (ir[2:0] == 3'b011) k = K_SHIFT;
    else if (ir[2:0] == 3'b111) k = K_ORI;
    else begin
      case (ir[3:0])
        4'b0000: k = K_LOAD;
        4'b0001: k = K_STOP;
        4'b0010: k = K_STORE;
        4'b0101: k = K_BZ;
        4'b1001: k = K_BNZ;
        4'b1101: k = K_BPZ;
        default: k = K_NOP;
      endcase
    end
    return k;
  endfunction

  always_comb begin
    kind2 = decode(IR2Out);
    kind3 = decode(IR3Out);
    kind4 = decode(IR4Out);
    taken = (kind3 == K_BZ && Z) || (kind3 == K_BNZ && !Z) || (kind3 == K_BPZ && !N);
    branching = taken;
    PCSel     = taken;
    MemWrite  = (kind3 == K_STORE);
    RFWrite   = 1'b0;
    RegWSel   = 2'd0;
    case (kind4)
      K_LOAD, K_ALU, K_SHIFT: begin
        RFWrite = 1'b1;
        RegWSel = IR4Out[7:6];
      end
      K_ORI: begin
        RFWrite = 1'b1;
        RegWSel = 2'd1;
      end
      default: ;
    endcase
  end

  // FREEZE is entered on the edge that moves stop into IR3, so the younger
  // instructions in IR1/IR2 are squashed on that same edge and never retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      IR1Out  <= NOP;
      IR2Out  <= NOP;
      IR3Out  <= NOP;
      IR4Out  <= NOP;
      state   <= RUN;
      PCWrite <= 1'b1;
      Halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          IR4Out <= IR3Out;
          if (taken) begin
            IR1Out <= NOP;
            IR2Out <= NOP;
            IR3Out <= NOP;
          end else if (kind2 == K_STOP) begin
            IR1Out  <= NOP;
            IR2Out  <= NOP;
            IR3Out  <= IR2Out;
            state   <= FREEZE;
            PCWrite <= 1'b0;
          end else begin
            IR1Out <= InstrIn;
            IR2Out <= IR1Out;
            IR3Out <= IR2Out;
          end
        end
        FREEZE: begin
          IR1Out <= NOP;
          IR2Out <= NOP;
          IR3Out <= IR2Out;
          IR4Out <= IR3Out;
          state  <= DRAIN;
        end
        DRAIN: begin
          IR1Out <= NOP;
          IR2Out <= NOP;
          IR3Out <= NOP;
          IR4Out <= IR3Out;
          state  <= HALT;
          Halted <= 1'b1;
        end
        HALT: begin
          IR1Out <= NOP;
          IR2Out <= NOP;
          IR3Out <= NOP;
          IR4Out <= NOP;
        end
      endcase
    end
  end

`ifdef IR_PIPE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RetireCount <= '0;
      FlushCount  <= '0;
    end else if (state != HALT) begin
      if (kind4 != K_NOP && RetireCount != '1) RetireCount <= RetireCount + 16'd1;
      if (taken && FlushCount != '1) FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule
